// File: rtl/alu_rs_if.sv
// Bundle between the dispatcher/CDB/ALU side and the ALU reservation station.
// The station side uses the slave modport; the environment drives through master.
interface alu_rs_if #(
  parameter int IQ_ADDR_W = 4,
  parameter int WORD_W    = 32,
  parameter int CALC_W    = 4
);
  logic                 rdy;
  logic                 update_stat;
  logic                 clear_flag_in;
  logic                 full_out;

  logic                 disp_enable_in;
  logic [CALC_W-1:0]    disp_calc_code_in;
  logic                 disp_lhs_ready_in;
  logic [WORD_W-1:0]    disp_lhs_in;
  logic [IQ_ADDR_W-1:0] disp_lhs_tag_in;
  logic                 disp_rhs_ready_in;
  logic [WORD_W-1:0]    disp_rhs_in;
  logic [IQ_ADDR_W-1:0] disp_rhs_tag_in;
  logic [IQ_ADDR_W-1:0] disp_pos_in_iq_in;

  logic                 cdb_enable_in;
  logic [IQ_ADDR_W-1:0] cdb_tag_in;
  logic [WORD_W-1:0]    cdb_value_in;

  logic                 alu_full_in;
  logic                 calc_enable_out;
  logic [CALC_W-1:0]    calc_code_out;
  logic [WORD_W-1:0]    lhs_out;
  logic [WORD_W-1:0]    rhs_out;
  logic [IQ_ADDR_W-1:0] pos_in_iq_out;

  modport master (
    output rdy, update_stat, clear_flag_in,
    output disp_enable_in, disp_calc_code_in,
    output disp_lhs_ready_in, disp_lhs_in, disp_lhs_tag_in,
    output disp_rhs_ready_in, disp_rhs_in, disp_rhs_tag_in,
    output disp_pos_in_iq_in,
    output cdb_enable_in, cdb_tag_in, cdb_value_in,
    output alu_full_in,
    input  full_out,
    input  calc_enable_out, calc_code_out, lhs_out, rhs_out, pos_in_iq_out
  );

  modport slave (
    input  rdy, update_stat, clear_flag_in,
    input  disp_enable_in, disp_calc_code_in,
    input  disp_lhs_ready_in, disp_lhs_in, disp_lhs_tag_in,
    input  disp_rhs_ready_in, disp_rhs_in, disp_rhs_tag_in,
    input  disp_pos_in_iq_in,
    input  cdb_enable_in, cdb_tag_in, cdb_value_in,
    input  alu_full_in,
    output full_out,
    output calc_enable_out, calc_code_out, lhs_out, rhs_out, pos_in_iq_out
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops until both operands are known,
// snoops the CDB for in-flight operands and issues the lowest-index ready entry.
module alu_rs #(
  parameter int RS_SIZE   = 8,
  parameter int IQ_ADDR_W = 4,
  parameter int WORD_W    = 32,
  parameter int CALC_W    = 4
) (
  input logic    clk,
  input logic    rst,
  alu_rs_if.slave bus
);
  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = $clog2(RS_SIZE) + 1;

  logic                 busy_reg    [RS_SIZE];
  logic [CALC_W-1:0]    code_reg    [RS_SIZE];
  logic                 lhs_rdy_reg [RS_SIZE];
  logic [WORD_W-1:0]    lhs_val_reg [RS_SIZE];
  logic [IQ_ADDR_W-1:0] lhs_tag_reg [RS_SIZE];
  logic                 rhs_rdy_reg [RS_SIZE];
  logic [WORD_W-1:0]    rhs_val_reg [RS_SIZE];
  logic [IQ_ADDR_W-1:0] rhs_tag_reg [RS_SIZE];
  logic [IQ_ADDR_W-1:0] pos_reg     [RS_SIZE];

  logic [CNT_W-1:0]     count_reg;
  logic                 full_reg;
  logic                 calc_enable_reg;
  logic [CALC_W-1:0]    calc_code_reg;
  logic [WORD_W-1:0]    lhs_out_reg;
  logic [WORD_W-1:0]    rhs_out_reg;
  logic [IQ_ADDR_W-1:0] pos_out_reg;

  logic [RS_SIZE-1:0]   ready_vec;
  logic [RS_SIZE-1:0]   free_vec;
  logic [RS_SIZE-1:0]   lhs_wake;
  logic [RS_SIZE-1:0]   rhs_wake;

  logic                 issue_found;
  logic [IDX_W-1:0]     issue_idx;
  logic                 free_found;
  logic [IDX_W-1:0]     free_idx;

  logic                 issue_go;
  logic                 disp_go;
  logic                 disp_lhs_byp;
  logic                 disp_rhs_byp;
  logic                 disp_lhs_rdy;
  logic                 disp_rhs_rdy;
  logic [WORD_W-1:0]    disp_lhs_val;
  logic [WORD_W-1:0]    disp_rhs_val;
  logic [CNT_W-1:0]     count_next;
  logic                 full_next;

  // Per-entry status taken from registered state only, so a wakeup on this
  // edge cannot make its entry eligible for issue until the next issue edge.
  genvar gi;
  generate
    for (gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      assign ready_vec[gi] = busy_reg[gi] & lhs_rdy_reg[gi] & rhs_rdy_reg[gi];
      assign free_vec[gi]  = ~busy_reg[gi];
      assign lhs_wake[gi]  = busy_reg[gi] & ~lhs_rdy_reg[gi] & bus.cdb_enable_in &
                             (lhs_tag_reg[gi] == bus.cdb_tag_in);
      assign rhs_wake[gi]  = busy_reg[gi] & ~rhs_rdy_reg[gi] & bus.cdb_enable_in &
                             (rhs_tag_reg[gi] == bus.cdb_tag_in);
    end
  endgenerate

  always_comb begin
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Same-cycle CDB bypass for operands arriving with the dispatch itself.
  assign disp_lhs_byp = ~bus.disp_lhs_ready_in & bus.cdb_enable_in &
                        (bus.disp_lhs_tag_in == bus.cdb_tag_in);
  assign disp_rhs_byp = ~bus.disp_rhs_ready_in & bus.cdb_enable_in &
                        (bus.disp_rhs_tag_in == bus.cdb_tag_in);
  assign disp_lhs_rdy = bus.disp_lhs_ready_in | disp_lhs_byp;
  assign disp_rhs_rdy = bus.disp_rhs_ready_in | disp_rhs_byp;
  assign disp_lhs_val = disp_lhs_byp ? bus.cdb_value_in : bus.disp_lhs_in;
  assign disp_rhs_val = disp_rhs_byp ? bus.cdb_value_in : bus.disp_rhs_in;

  assign issue_go   = ~bus.update_stat & ~bus.alu_full_in & issue_found;
  assign disp_go    = bus.disp_enable_in & ~full_reg & free_found;
  assign count_next = count_reg + CNT_W'(disp_go) - CNT_W'(issue_go);
  assign full_next  = (count_next == CNT_W'(RS_SIZE));

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        busy_reg[i]    <= 1'b0;
        lhs_rdy_reg[i] <= 1'b0;
        rhs_rdy_reg[i] <= 1'b0;
      end
      count_reg       <= '0;
      full_reg        <= 1'b0;
      calc_enable_reg <= 1'b0;
      calc_code_reg   <= '0;
      lhs_out_reg     <= '0;
      rhs_out_reg     <= '0;
      pos_out_reg     <= '0;
    end else if (bus.rdy) begin
      if (bus.clear_flag_in) begin
        for (int i = 0; i < RS_SIZE; i++) begin
          busy_reg[i] <= 1'b0;
        end
        count_reg       <= '0;
        full_reg        <= 1'b0;
        calc_enable_reg <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (lhs_wake[i]) begin
            lhs_rdy_reg[i] <= 1'b1;
            lhs_val_reg[i] <= bus.cdb_value_in;
          end
          if (rhs_wake[i]) begin
            rhs_rdy_reg[i] <= 1'b1;
            rhs_val_reg[i] <= bus.cdb_value_in;
          end
        end

        // Issue frees a busy entry; dispatch fills a slot that was free at the
        // start of the cycle, so the two never touch the same entry.
        if (issue_go) begin
          busy_reg[issue_idx] <= 1'b0;
        end
        if (disp_go) begin
          busy_reg[free_idx]    <= 1'b1;
          code_reg[free_idx]    <= bus.disp_calc_code_in;
          lhs_rdy_reg[free_idx] <= disp_lhs_rdy;
          lhs_val_reg[free_idx] <= disp_lhs_val;
          lhs_tag_reg[free_idx] <= bus.disp_lhs_tag_in;
          rhs_rdy_reg[free_idx] <= disp_rhs_rdy;
          rhs_val_reg[free_idx] <= disp_rhs_val;
          rhs_tag_reg[free_idx] <= bus.disp_rhs_tag_in;
          pos_reg[free_idx]     <= bus.disp_pos_in_iq_in;
        end

        // Capture-phase edges leave the issue outputs untouched for the ALU.
        if (!bus.update_stat) begin
          calc_enable_reg <= issue_go;
          if (issue_go) begin
            calc_code_reg <= code_reg[issue_idx];
            lhs_out_reg   <= lhs_val_reg[issue_idx];
            rhs_out_reg   <= rhs_val_reg[issue_idx];
            pos_out_reg   <= pos_reg[issue_idx];
          end
        end

        count_reg <= count_next;
        full_reg  <= full_next;
      end
    end
  end

  assign bus.full_out        = full_reg;
  assign bus.calc_enable_out = calc_enable_reg;
  assign bus.calc_code_out   = calc_code_reg;
  assign bus.lhs_out         = lhs_out_reg;
  assign bus.rhs_out         = rhs_out_reg;
  assign bus.pos_in_iq_out   = pos_out_reg;
endmodule
